// File: rtl/sdram_cache_pkg.sv
// Shared types and constants for the SDRAM read cache: FSM state encoding and tag width.
package sdram_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WRITE,
        RELEASE,
        RESPOND
    } cache_state_e;

    localparam int unsigned DEF_ADDRESS_WIDTH = 23;
    localparam int unsigned DEF_INDEX_BITS    = 6;
    localparam int unsigned TAG_BITS          = DEF_ADDRESS_WIDTH - DEF_INDEX_BITS;

    // Tag width for any address/index split.
    function automatic int unsigned tag_bits(input int unsigned aw, input int unsigned ib);
        return aw - ib;
    endfunction

endpackage

// File: rtl/sdram_cache_lines.sv
// Line storage for the direct-mapped cache: valid/tag/data per line, one byte-enabled write
// port, one asynchronous read port, and a single-cycle invalidate-all.
module sdram_cache_lines
    import sdram_cache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
    parameter int unsigned TAG_W      = TAG_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clear_all,
    input  logic                  i_we,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [TAG_W-1:0]      i_wr_tag,
    input  logic [3:0]            i_wr_be,
    input  logic [31:0]           i_wr_data,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    output logic                  o_rd_valid_c,
    output logic [TAG_W-1:0]      o_rd_tag_c,
    output logic [31:0]           o_rd_data_c
);

    localparam int unsigned LINES = 2 ** INDEX_BITS;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    always_ff @(posedge clk) begin
        if (reset || i_clear_all) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_index] <= i_wr_tag;
            for (int b = 0; b < 4; b++) begin
                if (i_wr_be[b]) begin
                    r_data[i_wr_index][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

    assign o_rd_valid_c = r_valid[i_rd_index];
    assign o_rd_tag_c   = r_tag[i_rd_index];
    assign o_rd_data_c  = r_data[i_rd_index];

endmodule

// File: rtl/sdram_read_cache.sv
// Direct-mapped, write-through, one-word-per-line cache in front of an SDRAM controller.
// Optional hit/miss counters are built when SDRAM_CACHE_STATS_EN is defined.
module sdram_read_cache
    import sdram_cache_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 23,
    parameter int unsigned INDEX_BITS    = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_valid,
    input  logic [ADDRESS_WIDTH-1:0] cpu_address,
    input  logic [31:0]              cpu_wdata,
    input  logic [3:0]               cpu_nwr,
    output logic [31:0]              cpu_rdata,
    output logic                     cpu_ready,
    input  logic                     flush,
`ifdef SDRAM_CACHE_STATS_EN
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count,
`endif
    output logic                     mem_req,
    input  logic                     mem_ack,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [31:0]              mem_data_out,
    input  logic [31:0]              mem_data_in,
    output logic [3:0]               mem_nwr
);

    localparam int unsigned TAG_W = tag_bits(ADDRESS_WIDTH, INDEX_BITS);

    cache_state_e             r_state;
    cache_state_e             w_next;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [31:0]              r_wdata;
    logic [3:0]               r_nwr;
    logic [31:0]              r_cpu_rdata;
    logic                     r_cpu_ready;
    logic                     r_skip;
    logic                     r_mem_req;
    logic                     r_flush_pend;

    logic                     w_accept;
    logic                     w_hit_accept;
    logic                     w_clear;
    logic                     w_line_we;
    logic [3:0]               w_line_be;
    logic [31:0]              w_line_wdata;
    logic [INDEX_BITS-1:0]    w_rd_index;
    logic [TAG_W-1:0]         w_cmp_tag;
    logic                     w_rd_valid;
    logic [TAG_W-1:0]         w_rd_tag;
    logic [31:0]              w_rd_data;
    logic                     w_hit;

    sdram_cache_lines #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_lines (
        .clk          (clk),
        .reset        (reset),
        .i_clear_all  (w_clear),
        .i_we         (w_line_we),
        .i_wr_index   (r_addr[INDEX_BITS-1:0]),
        .i_wr_tag     (r_addr[ADDRESS_WIDTH-1:INDEX_BITS]),
        .i_wr_be      (w_line_be),
        .i_wr_data    (w_line_wdata),
        .i_rd_index   (w_rd_index),
        .o_rd_valid_c (w_rd_valid),
        .o_rd_tag_c   (w_rd_tag),
        .o_rd_data_c  (w_rd_data)
    );

    // Lookup the incoming request while idle, the latched request otherwise.
    always_comb begin
        w_rd_index = r_addr[INDEX_BITS-1:0];
        w_cmp_tag  = r_addr[ADDRESS_WIDTH-1:INDEX_BITS];
        if (r_state == IDLE) begin
            w_rd_index = cpu_address[INDEX_BITS-1:0];
            w_cmp_tag  = cpu_address[ADDRESS_WIDTH-1:INDEX_BITS];
        end
    end

    assign w_hit = w_rd_valid && (w_rd_tag == w_cmp_tag);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and line-write control; flush wins over a same-cycle request.
    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_hit_accept = 1'b0;
        w_clear      = 1'b0;
        w_line_we    = 1'b0;
        w_line_be    = 4'h0;
        w_line_wdata = 32'h0;
        unique case (r_state)
            IDLE: begin
                if (flush || r_flush_pend) begin
                    w_clear = 1'b1;
                end else if (cpu_valid && !r_cpu_ready && !r_skip) begin
                    w_accept = 1'b1;
                    if (cpu_nwr != 4'hF) begin
                        w_next = WRITE;
                    end else if (w_hit) begin
                        w_hit_accept = 1'b1;
                    end else begin
                        w_next = FILL;
                    end
                end
            end
            FILL: begin
                if (mem_ack) begin
                    w_line_we    = 1'b1;
                    w_line_be    = 4'hF;
                    w_line_wdata = mem_data_in;
                    w_next       = RELEASE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    w_line_we    = w_hit;
                    w_line_be    = ~r_nwr;
                    w_line_wdata = r_wdata;
                    w_next       = RELEASE;
                end
            end
            RELEASE: begin
                if (!mem_ack) begin
                    w_next = RESPOND;
                end
            end
            RESPOND: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // r_skip masks the cycle after a completion, when the CPU's valid may still be stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_ready  <= 1'b0;
            r_skip       <= 1'b0;
            r_mem_req    <= 1'b0;
            r_nwr        <= 4'hF;
            r_flush_pend <= 1'b0;
        end else begin
            r_cpu_ready <= w_hit_accept || (w_next == RESPOND);
            r_skip      <= r_cpu_ready;
            r_mem_req   <= (w_next == FILL) || (w_next == WRITE);
            if (w_accept) begin
                r_nwr <= cpu_nwr;
            end
            if (w_clear) begin
                r_flush_pend <= 1'b0;
            end else if (flush && (r_state != IDLE)) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= cpu_address;
            r_wdata <= cpu_wdata;
        end
        if (w_hit_accept) begin
            r_cpu_rdata <= w_rd_data;
        end else if ((r_state == FILL) && mem_ack) begin
            r_cpu_rdata <= mem_data_in;
        end
    end

    assign cpu_ready    = r_cpu_ready;
    assign cpu_rdata    = r_cpu_rdata;
    assign mem_req      = r_mem_req;
    assign mem_address  = r_addr;
    assign mem_data_out = r_wdata;
    assign mem_nwr      = r_nwr;

`ifdef SDRAM_CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_hit_count  <= 32'h0;
            r_miss_count <= 32'h0;
        end else begin
            if (w_hit_accept) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if ((r_state == RESPOND) && (r_nwr == 4'hF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_sdram_read_cache.sv
// Self-checking bench for sdram_read_cache: directed vector table, reset/stale-valid
// sequences, then random traffic against a memory-is-truth cache model.
module tb_sdram_read_cache;

    localparam int K_HIT  = 0;
    localparam int K_MISS = 1;
    localparam int K_WR   = 2;
    localparam int NV     = 20;

    typedef struct {
        logic [22:0] addr;
        logic [3:0]  nwr;
        logic [31:0] wdata;
        int          flush_cyc;
        int          kind;
        logic [31:0] rdata;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        cpu_valid;
    logic [22:0] cpu_address;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_nwr;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        flush;
    logic        mem_req;
    logic        mem_ack;
    logic [22:0] mem_address;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_nwr;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_req = 0;
    logic [22:0] cap_addr;
    logic [3:0]  cap_nwr;
    logic [31:0] cap_data;

    logic [31:0] mem [int unsigned];
    logic [63:0] mv;
    logic [16:0] mt [64];
    vec_t        vecs [NV];

    sdram_read_cache dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_valid    (cpu_valid),
        .cpu_address  (cpu_address),
        .cpu_wdata    (cpu_wdata),
        .cpu_nwr      (cpu_nwr),
        .cpu_rdata    (cpu_rdata),
        .cpu_ready    (cpu_ready),
        .flush        (flush),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_nwr      (mem_nwr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [22:0] a);
        if (!mem.exists(32'(a))) mem[32'(a)] = {9'h0, a} ^ 32'hA5C3_0000;
        return mem[32'(a)];
    endfunction

    function automatic void mem_wr(input logic [22:0] a, input logic [3:0] nwr, input logic [31:0] d);
        logic [31:0] cur;
        cur = mem_rd(a);
        for (int b = 0; b < 4; b++) if (!nwr[b]) cur[8*b +: 8] = d[8*b +: 8];
        mem[32'(a)] = cur;
    endfunction

    function automatic bit model_hit(input logic [22:0] a);
        return mv[a[5:0]] && (mt[a[5:0]] == a[22:6]);
    endfunction

    function automatic void model_apply(input logic [22:0] a, input int kind, input int fl);
        if (kind == K_MISS) begin
            mv[a[5:0]] = 1'b1;
            mt[a[5:0]] = a[22:6];
        end
        if (fl != 0) mv = '0;
    endfunction

    // SDRAM controller stand-in: 4-phase handshake, random latency, byte-masked writes.
    initial begin : responder
        bit seen;
        int dly;
        seen        = 0;
        dly         = 0;
        mem_ack     = 1'b0;
        mem_data_in = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mem_ack = 1'b0;
                seen    = 0;
            end else if (!mem_ack && mem_req) begin
                if (!seen) begin
                    seen     = 1;
                    n_req++;
                    cap_addr = mem_address;
                    cap_nwr  = mem_nwr;
                    cap_data = mem_data_out;
                    dly      = int'($urandom_range(2, 4));
                end else begin
                    chk("mem_hold", 32'((mem_address !== cap_addr) || (mem_nwr !== cap_nwr)
                                        || (mem_data_out !== cap_data)), 32'h0);
                    dly--;
                    if (dly == 0) begin
                        if (cap_nwr == 4'hF) mem_data_in = mem_rd(cap_addr);
                        else mem_wr(cap_addr, cap_nwr, cap_data);
                        mem_ack = 1'b1;
                    end
                end
            end else if (mem_ack && !mem_req) begin
                mem_ack = 1'b0;
                seen    = 0;
            end
        end
    end

    task automatic run_txn(input logic [22:0] a, input logic [3:0] nwr, input logic [31:0] wd,
                           input int fl, input int kind, input logic [31:0] exp_d);
        int req0;
        int cyc;
        bit got;
        req0        = n_req;
        cpu_address = a;
        cpu_nwr     = nwr;
        cpu_wdata   = wd;
        cpu_valid   = 1'b1;
        cyc         = 0;
        got         = 0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            flush = (cyc == fl);
            if (cpu_ready) got = 1;
        end
        flush = 1'b0;
        chk("ready_seen", 32'(got), 32'h1);
        if (kind == K_HIT) chk("hit_latency", 32'(cyc), 32'h1);
        if (kind != K_WR) chk("rdata", cpu_rdata, exp_d);
        cpu_valid = 1'b0;
        chk("mem_req_count", 32'(n_req - req0), (kind == K_HIT) ? 32'h0 : 32'h1);
        if (kind != K_HIT) begin
            chk("mem_address", 32'(cap_addr), 32'(a));
            chk("mem_nwr", 32'(cap_nwr), 32'(nwr));
            if (kind == K_WR) chk("mem_data_out", cap_data, wd);
        end
        @(negedge clk);
        chk("ready_pulse_width", 32'(cpu_ready), 32'h0);
        @(negedge clk);
    endtask

    initial begin : main
        logic [22:0] a;
        logic [3:0]  nwr;
        logic [31:0] wd;
        logic [16:0] tag;
        int          kind;
        int          fl;
        int          req0;
        int          cyc;

        reset       = 1'b1;
        cpu_valid   = 1'b0;
        cpu_address = '0;
        cpu_wdata   = '0;
        cpu_nwr     = 4'hF;
        flush       = 1'b0;
        mv          = '0;
        mem[32'h10]     = 32'hDEADBEEF;
        mem[32'h50]     = 32'h12345678;
        mem[32'h20]     = 32'hCAFEF00D;
        mem[32'h0]      = 32'h0A0A0A0A;
        mem[32'h7FFFFF] = 32'hF0F0F0F0;
        mem[32'h7FFFC0] = 32'h55AA55AA;
        mem[32'h123]    = 32'h11223344;

        vecs[0]  = '{23'h000010, 4'hF,    32'h0,        0, K_MISS, 32'hDEADBEEF};
        vecs[1]  = '{23'h000010, 4'hF,    32'h0,        0, K_HIT,  32'hDEADBEEF};
        vecs[2]  = '{23'h000010, 4'b1100, 32'h0000CAFE, 0, K_WR,   32'h0};
        vecs[3]  = '{23'h000010, 4'hF,    32'h0,        0, K_HIT,  32'hDEADCAFE};
        vecs[4]  = '{23'h000050, 4'hF,    32'h0,        0, K_MISS, 32'h12345678};
        vecs[5]  = '{23'h000010, 4'hF,    32'h0,        0, K_MISS, 32'hDEADCAFE};
        vecs[6]  = '{23'h000020, 4'hF,    32'h0,        1, K_MISS, 32'hCAFEF00D};
        vecs[7]  = '{23'h000020, 4'hF,    32'h0,        0, K_MISS, 32'hCAFEF00D};
        vecs[8]  = '{23'h000010, 4'hF,    32'h0,        0, K_MISS, 32'hDEADCAFE};
        vecs[9]  = '{23'h000000, 4'hF,    32'h0,        0, K_MISS, 32'h0A0A0A0A};
        vecs[10] = '{23'h7FFFC0, 4'hF,    32'h0,        0, K_MISS, 32'h55AA55AA};
        vecs[11] = '{23'h000000, 4'hF,    32'h0,        0, K_MISS, 32'h0A0A0A0A};
        vecs[12] = '{23'h7FFFFF, 4'hF,    32'h0,        0, K_MISS, 32'hF0F0F0F0};
        vecs[13] = '{23'h000000, 4'hF,    32'h0,        0, K_HIT,  32'h0A0A0A0A};
        vecs[14] = '{23'h7FFFFF, 4'hF,    32'h0,        0, K_HIT,  32'hF0F0F0F0};
        vecs[15] = '{23'h000123, 4'b0110, 32'hAABBCCDD, 0, K_WR,   32'h0};
        vecs[16] = '{23'h000123, 4'hF,    32'h0,        0, K_MISS, 32'hAA2233DD};
        vecs[17] = '{23'h000123, 4'hF,    32'h0,        0, K_HIT,  32'hAA2233DD};
        vecs[18] = '{23'h000123, 4'b0000, 32'h01020304, 0, K_WR,   32'h0};
        vecs[19] = '{23'h000123, 4'hF,    32'h0,        0, K_HIT,  32'h01020304};

        repeat (3) @(negedge clk);
        chk("reset_cpu_ready", 32'(cpu_ready), 32'h0);
        chk("reset_mem_req", 32'(mem_req), 32'h0);
        chk("reset_mem_nwr", 32'(mem_nwr), 32'hF);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_txn(vecs[i].addr, vecs[i].nwr, vecs[i].wdata, vecs[i].flush_cyc,
                    vecs[i].kind, vecs[i].rdata);
            model_apply(vecs[i].addr, vecs[i].kind, vecs[i].flush_cyc);
        end

        // Reset while a fill is outstanding, then the first read misses.
        a           = 23'h0002A5;
        cpu_address = a;
        cpu_nwr     = 4'hF;
        cpu_valid   = 1'b1;
        cyc         = 0;
        while (!mem_req && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("req_before_reset", 32'(mem_req), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_mem_req", 32'(mem_req), 32'h0);
        chk("reset_mid_cpu_ready", 32'(cpu_ready), 32'h0);
        cpu_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mv    = '0;
        @(negedge clk);
        run_txn(a, 4'hF, 32'h0, 0, K_MISS, mem_rd(a));
        model_apply(a, K_MISS, 0);

        // Valid held past completion must not be taken as a new request.
        a           = 23'h0003E7;
        req0        = n_req;
        cpu_address = a;
        cpu_nwr     = 4'hF;
        cpu_valid   = 1'b1;
        cyc         = 0;
        while (!cpu_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("stale_first_ready", 32'(cpu_ready), 32'h1);
        chk("stale_first_rdata", cpu_rdata, mem_rd(a));
        @(negedge clk);
        chk("stale_ready_s", 32'(cpu_ready), 32'h0);
        @(negedge clk);
        chk("stale_ready_t", 32'(cpu_ready), 32'h0);
        cpu_valid = 1'b0;
        chk("stale_req_count", 32'(n_req - req0), 32'h1);
        repeat (2) @(negedge clk);
        model_apply(a, K_MISS, 0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                mv    = '0;
            end
            case ($urandom_range(0, 2))
                0:       tag = 17'h0;
                1:       tag = 17'h1;
                default: tag = 17'h1FFFF;
            endcase
            a    = {tag, 6'($urandom_range(0, 7))};
            nwr  = ($urandom_range(0, 99) < 30) ? 4'($urandom_range(0, 14)) : 4'hF;
            wd   = $urandom;
            kind = (nwr != 4'hF) ? K_WR : (model_hit(a) ? K_HIT : K_MISS);
            fl   = (kind != K_HIT && $urandom_range(0, 7) == 0) ? 1 : 0;
            run_txn(a, nwr, wd, fl, kind, (kind == K_WR) ? 32'h0 : mem_rd(a));
            model_apply(a, kind, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
